// File: rtl/dob_reset_sequencer.sv
// dob_reset_sequencer
//   Staged reset sequencer for the data-output-block clock domain. Keeps all
//   channel resets asserted while the PLL is unlocked or the block is in reset,
//   waits a hold time after synchronised lock, then releases the channels one
//   at a time in ascending order (serialiser, encoder, FIFO readout). Also
//   handles software reset requests and counts PLL lock losses.
// Ports
//   clock       in   DOB clock, rising edge
//   reset       in   synchronous active-high block reset
//   locked      in   asynchronous PLL lock, 2-FF synchronised internally
//   sw_rst_req  in   single-cycle software reset request
//   rst_out     out  [NCH-1:0] active-high per-channel reset, registered
//   seq_done    out  high while all channels are released, registered
//   lock_loss   out  [CNT_W-1:0] saturating lock-loss count, registered
module dob_reset_sequencer #(
  parameter int unsigned NCH       = 3,
  parameter int unsigned HOLD_CYC  = 4,
  parameter int unsigned STAGE_GAP = 2,
  parameter int unsigned SW_CYC    = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             locked,
  input  logic             sw_rst_req,
  output logic [NCH-1:0]   rst_out,
  output logic             seq_done,
  output logic [CNT_W-1:0] lock_loss
);

  localparam int unsigned MAX_HS  = (HOLD_CYC > STAGE_GAP) ? HOLD_CYC : STAGE_GAP;
  localparam int unsigned MAX_CYC = (MAX_HS > SW_CYC) ? MAX_HS : SW_CYC;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);
  localparam int unsigned SW      = $clog2(NCH + 1);
  localparam bit          SINGLE  = (NCH == 1);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    HOLD      = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    SW_RST    = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [SW-1:0]    stage, stage_nxt;
  logic [NCH-1:0]   rst_out_nxt;
  logic             seq_done_nxt;
  logic [CNT_W-1:0] lock_loss_nxt;
  logic [1:0]       sync;
  logic             locked_s;

  // Two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge clock) begin
    if (reset) sync <= 2'b00;
    else       sync <= {sync[0], locked};
  end

  assign locked_s = sync[1];

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      stage     <= '0;
      rst_out   <= '1;
      seq_done  <= 1'b0;
      lock_loss <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      stage     <= stage_nxt;
      rst_out   <= rst_out_nxt;
      seq_done  <= seq_done_nxt;
      lock_loss <= lock_loss_nxt;
    end
  end

  // Next-state and next-output logic. Channels are released by shifting a
  // zero in at bit 0, so the asserted set is always a contiguous top run.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    stage_nxt     = stage;
    rst_out_nxt   = rst_out;
    seq_done_nxt  = seq_done;
    lock_loss_nxt = lock_loss;

    if (state != WAIT_LOCK && !locked_s) begin
      // Lock loss outranks a simultaneous software request
      state_nxt    = WAIT_LOCK;
      cnt_nxt      = '0;
      stage_nxt    = '0;
      rst_out_nxt  = '1;
      seq_done_nxt = 1'b0;
      if (lock_loss != '1) lock_loss_nxt = lock_loss + CNT_W'(1);
    end else begin
      unique case (state)
        WAIT_LOCK: begin
          rst_out_nxt  = '1;
          seq_done_nxt = 1'b0;
          if (locked_s) begin
            state_nxt = HOLD;
            cnt_nxt   = '0;
          end
        end

        HOLD, RELEASE, RUN: begin
          if (sw_rst_req) begin
            state_nxt    = SW_RST;
            cnt_nxt      = '0;
            stage_nxt    = '0;
            rst_out_nxt  = '1;
            seq_done_nxt = 1'b0;
          end else if (state == HOLD) begin
            if (cnt == CW'(HOLD_CYC - 1)) begin
              rst_out_nxt = rst_out << 1;
              cnt_nxt     = '0;
              stage_nxt   = SW'(1);
              if (SINGLE) begin
                state_nxt    = RUN;
                seq_done_nxt = 1'b1;
              end else begin
                state_nxt = RELEASE;
              end
            end else begin
              cnt_nxt = cnt + CW'(1);
            end
          end else if (state == RELEASE) begin
            if (cnt == CW'(STAGE_GAP - 1)) begin
              rst_out_nxt = rst_out << 1;
              cnt_nxt     = '0;
              if (stage == SW'(NCH - 1)) begin
                state_nxt    = RUN;
                seq_done_nxt = 1'b1;
              end else begin
                stage_nxt = stage + SW'(1);
              end
            end else begin
              cnt_nxt = cnt + CW'(1);
            end
          end
        end

        SW_RST: begin
          rst_out_nxt  = '1;
          seq_done_nxt = 1'b0;
          if (sw_rst_req) begin
            cnt_nxt = '0;
          end else if (cnt == CW'(SW_CYC - 1)) begin
            state_nxt = HOLD;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end

        default: begin
          state_nxt   = WAIT_LOCK;
          cnt_nxt     = '0;
          stage_nxt   = '0;
          rst_out_nxt = '1;
        end
      endcase
    end
  end

endmodule
